// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder.
// State encoding and counter sizing used by rca_seq_ctrl.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of a counter that spans 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// CHUNK-bit combinational ripple-carry adder slice.
// Built from a chain of full-adder cells; holds no state.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle signed adder: one shared rca_chunk, LSB slice first.
// Define RCA_SEQ_OVF_EN to add the registered ovf output.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             busy
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("rca_seq_ctrl: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sgn;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CHUNK-1:0] sum;
  logic             cout;

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (sa[CHUNK-1:0]),
    .b   (sb[CHUNK-1:0]),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  // Newest slice sum enters the result from the top
  if (NCHUNK == 1) begin : g_one
    assign res_nxt = sum;
  end else begin : g_many
    assign res_nxt = {sum, res[WIDTH-1:CHUNK]};
  end

  // Sequencer: accept, step one slice per cycle, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      sgn       <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sa       <= a;
            sb       <= b;
            sgn      <= a[WIDTH-1] ^ b[WIDTH-1];
            carry    <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt;
          carry <= cout;
          sa    <= sa >> CHUNK;
          sb    <= sb >> CHUNK;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            out       <= {sgn ^ cout, res_nxt};
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef RCA_SEQ_OVF_EN
            ovf       <= sgn ^ cout ^ res_nxt[WIDTH-1];
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: CHUNK=8, 32 and 4 instances side by side.
// Checks against plain signed arithmetic.
module tb_rca_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [2:0]  busy;
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic [32:0] res_o [3];
`ifdef RCA_SEQ_OVF_EN
  logic [2:0]  ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
    rca_seq_ctrl #(
      .WIDTH(32),
      .CHUNK(CH)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (av[g]),
      .b        (bv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out      (res_o[g]),
      .busy     (busy[g])
`ifdef RCA_SEQ_OVF_EN
      ,
      .ovf      (ovf[g])
`endif
    );
  end

  function automatic int nch(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
  endfunction

  function automatic logic [32:0] model_sum(input logic [31:0] x,
                                            input logic [31:0] y);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
    return 33'(s);
  endfunction

  function automatic logic model_ovf(input logic [31:0] x,
                                     input logic [31:0] y);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic run_op(input int k, input logic [31:0] x,
                        input logic [31:0] y,
                        output logic [32:0] r, output int lat,
                        output logic ov);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (in_ready[k] !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_wait k=%0d got=%b want=1", k, in_ready[k]);
    end
    in_valid[k]  = 1'b1;
    av[k]        = x;
    bv[k]        = y;
    out_ready[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    av[k]       = $urandom;
    bv[k]       = $urandom;
    lat = 0;
    while (!out_valid[k] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r  = res_o[k];
    ov = 1'b0;
`ifdef RCA_SEQ_OVF_EN
    ov = ovf[k];
`endif
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    for (int k = 0; k < 3; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (res_o[k] !== 33'h0 || out_valid[k] !== 1'b0 ||
          busy[k] !== 1'b0 || in_ready[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset k=%0d got out=%h ov=%b busy=%b ir=%b want 0",
                 k, res_o[k], out_valid[k], busy[k], in_ready[k]);
      end
`ifdef RCA_SEQ_OVF_EN
      tests++;
      if (ovf[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_ovf k=%0d got=%b want=0", k, ovf[k]);
      end
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (in_ready[k] !== 1'b1) begin
        fails++;
        $display("FAIL in_ready_rise k=%0d got=%b want=1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [32:0] es [3];
    logic        os [3];
    logic [32:0] r;
    int          lat;
    logic        ov;
    xs[0] = 32'h7FFF_FFFF; ys[0] = 32'h0000_0001;
    es[0] = 33'h0_8000_0000; os[0] = 1'b1;
    xs[1] = 32'hFFFF_FFFF; ys[1] = 32'hFFFF_FFFF;
    es[1] = 33'h1_FFFF_FFFE; os[1] = 1'b0;
    xs[2] = 32'h8000_0000; ys[2] = 32'h8000_0000;
    es[2] = 33'h1_0000_0000; os[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(0, xs[i], ys[i], r, lat, ov);
      tests++;
      if (r !== es[i]) begin
        fails++;
        $display("FAIL directed_sum%0d got=%h want=%h", i, r, es[i]);
      end
      tests++;
      if (lat != 4) begin
        fails++;
        $display("FAIL directed_lat%0d got=%0d want=4", i, lat);
      end
`ifdef RCA_SEQ_OVF_EN
      tests++;
      if (ov !== os[i]) begin
        fails++;
        $display("FAIL directed_ovf%0d got=%b want=%b", i, ov, os[i]);
      end
`else
      if (ov !== 1'b0 && os[i] === 1'b0) $display("note: ov unused");
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x1, y1, x2, y2;
    int n;
    x1 = 32'h1234_5678; y1 = 32'h0FED_CBA9;
    x2 = $urandom;      y2 = $urandom;
    n = 0;
    @(negedge clk);
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid[0]  = 1'b1;
    av[0]        = x1;
    bv[0]        = y1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    in_valid[0] = 1'b1;
    av[0]       = x2;
    bv[0]       = y2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (res_o[0] !== model_sum(x1, y1) || out_valid[0] !== 1'b1 ||
          in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d got out=%h ov=%b ir=%b busy=%b want %h 1 0 1",
                 i, res_o[0], out_valid[0], in_ready[0], busy[0],
                 model_sum(x1, y1));
      end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got ov=%b ir=%b want 0 1",
               out_valid[0], in_ready[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_accept2 busy got=%b want=1", busy[0]);
    end
    n = 0;
    while (!out_valid[0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (res_o[0] !== model_sum(x2, y2) || n != 4) begin
      fails++;
      $display("FAIL bp_second got=%h lat=%0d want=%h lat=4",
               res_o[0], n, model_sum(x2, y2));
    end
  endtask

  task automatic test_reset_abort();
    logic [32:0] r;
    int          lat;
    logic        ov;
    int          n;
    bit          seen;
    n = 0;
    @(negedge clk);
    while (!in_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid[0]  = 1'b1;
    av[0]        = 32'h1111_1111;
    bv[0]        = 32'h2222_2222;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (res_o[0] !== 33'h0 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear got out=%h ov=%b busy=%b want 0 0 0",
               res_o[0], out_valid[0], busy[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_stale got out_valid=1 want=0");
    end
    run_op(0, 32'd5, -32'sd7, r, lat, ov);
    tests++;
    if (r !== 33'h1_FFFF_FFFE || lat != 4) begin
      fails++;
      $display("FAIL abort_next got=%h lat=%0d want=1fffffffe lat=4", r, lat);
    end
  endtask

  task automatic test_random(input int k, input int cnt);
    logic [31:0] x, y;
    logic [32:0] r;
    int          lat;
    logic        ov;
    for (int i = 0; i < cnt; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 17 == 0) x = 32'h8000_0000 | (x & 32'h1);
      if (i % 19 == 0) y = 32'h7FFF_FFFF;
      run_op(k, x, y, r, lat, ov);
      tests++;
      if (r !== model_sum(x, y)) begin
        fails++;
        $display("FAIL rand_sum k=%0d a=%h b=%h got=%h want=%h",
                 k, x, y, r, model_sum(x, y));
      end
      tests++;
      if (lat != nch(k)) begin
        fails++;
        $display("FAIL rand_lat k=%0d got=%0d want=%0d", k, lat, nch(k));
      end
`ifdef RCA_SEQ_OVF_EN
      tests++;
      if (ov !== model_ovf(x, y)) begin
        fails++;
        $display("FAIL rand_ovf k=%0d a=%h b=%h got=%b want=%b",
                 k, x, y, ov, model_ovf(x, y));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random(0, 200);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
